// File: rtl/load_store_queue.sv
// In-order load/store queue sitting between issue and the memory controller.
// Memory ops wait in a circular FIFO, pick up operands from the CDB and execute
// one at a time from the head. Loads report on out_*. A store first reports
// completion to the ROB (out_value 0), then writes memory once committed.
//
// Ports
//   clk_in, rst_in        clock, synchronous active-low reset
//   rdy_in                global enable; low freezes all state
//   issue_*               new op (op, ROB tag, base v1/q1, store data v2/q2, offset)
//   lsq_full              queue holds DEPTH entries; issue is ignored
//   cdb_*                 operand wakeup broadcast
//   commit_store          ROB commits the oldest store
//   rob_head              current ROB head (IO-safe build only)
//   flush                 mispredict; drops every uncommitted entry
//   mem_*                 request/response handshake with the memory controller
//   out_valid/rob/value   result pulse to the RS bypass and ROB
//
// Build option: define LSQ_IO_SAFE_EN to hold loads at or above IO_BASE until
// they reach the ROB head, so IO reads are never speculative.
module load_store_queue #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ROB_W   = 4,
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             issue_valid,
  input  logic [2:0]       issue_op,
  input  logic [ROB_W-1:0] issue_rob,
  input  logic             issue_q1_rdy,
  input  logic [31:0]      issue_v1,
  input  logic [ROB_W-1:0] issue_q1,
  input  logic             issue_q2_rdy,
  input  logic [31:0]      issue_v2,
  input  logic [ROB_W-1:0] issue_q2,
  input  logic [31:0]      issue_imm,
  output logic             lsq_full,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_rob,
  input  logic [31:0]      cdb_value,
  input  logic             commit_store,
  input  logic [ROB_W-1:0] rob_head,
  input  logic             flush,
  output logic             mem_req,
  output logic             mem_rw,
  output logic [1:0]       mem_width,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_done,
  input  logic [31:0]      mem_rdata,
  output logic             out_valid,
  output logic [ROB_W-1:0] out_rob,
  output logic [31:0]      out_value
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {StIdle, StWait} state_e;

  // Entry storage
  logic [2:0]       ent_op_q  [DEPTH];
  logic [ROB_W-1:0] ent_rob_q [DEPTH];
  logic [ROB_W-1:0] ent_q1_q  [DEPTH];
  logic [ROB_W-1:0] ent_q2_q  [DEPTH];
  logic [31:0]      ent_v1_q  [DEPTH];
  logic [31:0]      ent_v2_q  [DEPTH];
  logic [31:0]      ent_imm_q [DEPTH];
  logic [DEPTH-1:0] ent_r1_q, ent_r2_q, ent_rep_q;

  // Control state
  state_e          state_q, state_d;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  // Committed stores still queued; they always sit contiguously at the head
  logic [CntW-1:0] commit_cnt_q, commit_cnt_d;
  // In-flight load was flushed: finish the handshake but drop the result
  logic            kill_q, kill_d;

  logic             mem_req_q, mem_req_d, mem_rw_q, mem_rw_d;
  logic [1:0]       mem_width_q, mem_width_d;
  logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic             out_valid_q, out_valid_d;
  logic [ROB_W-1:0] out_rob_q, out_rob_d;
  logic [31:0]      out_value_q, out_value_d;

  logic             push, pop, store_pop, set_rep;
  logic             iss_hit1, iss_hit2;
  logic [2:0]       head_op;
  logic             head_store, head_r1, head_r2, head_rep;
  logic [31:0]      head_addr, load_ext;
  logic [1:0]       head_width;
  logic             io_ok;

  assign lsq_full  = (count_q == CntW'(DEPTH));
  assign mem_req   = mem_req_q;
  assign mem_rw    = mem_rw_q;
  assign mem_width = mem_width_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign out_valid = out_valid_q;
  assign out_rob   = out_rob_q;
  assign out_value = out_value_q;

  assign iss_hit1   = cdb_valid && (issue_q1 == cdb_rob);
  assign iss_hit2   = cdb_valid && (issue_q2 == cdb_rob);
  assign head_op    = ent_op_q[head_q];
  assign head_store = (head_op == 3'd3) || (head_op == 3'd6) || (head_op == 3'd7);
  assign head_r1    = ent_r1_q[head_q];
  assign head_r2    = ent_r2_q[head_q];
  assign head_rep   = ent_rep_q[head_q];
  assign head_addr  = ent_v1_q[head_q] + ent_imm_q[head_q];

`ifdef LSQ_IO_SAFE_EN
  assign io_ok = (head_addr < IO_BASE) || (rob_head == ent_rob_q[head_q]);
`else
  logic unused_io;
  assign unused_io = ^{rob_head, IO_BASE};
  assign io_ok     = 1'b1;
`endif

  always_comb begin
    case (head_op)
      3'd0, 3'd3, 3'd4: head_width = 2'd0;
      3'd1, 3'd5, 3'd6: head_width = 2'd1;
      default:          head_width = 2'd2;
    endcase
  end

  always_comb begin
    case (head_op)
      3'd0:    load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'd4:    load_ext = {24'b0, mem_rdata[7:0]};
      3'd1:    load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'd5:    load_ext = {16'b0, mem_rdata[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    commit_cnt_d = commit_cnt_q;
    kill_d       = kill_q;
    mem_req_d    = mem_req_q;
    mem_rw_d     = mem_rw_q;
    mem_width_d  = mem_width_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    out_valid_d  = 1'b0;
    out_rob_d    = out_rob_q;
    out_value_d  = out_value_q;
    set_rep      = 1'b0;
    pop          = 1'b0;
    store_pop    = 1'b0;
    push         = issue_valid && !lsq_full && !flush;

    case (state_q)
      StIdle: begin
        // Head is held back on a flush cycle; a surviving committed store starts next cycle
        if (count_q != '0 && !flush) begin
          if (!head_store) begin
            if (head_r1 && io_ok) begin
              mem_req_d   = 1'b1;
              mem_rw_d    = 1'b0;
              mem_addr_d  = head_addr;
              mem_width_d = head_width;
              mem_wdata_d = '0;
              state_d     = StWait;
            end
          end else if (!head_rep) begin
            if (head_r1 && head_r2) begin
              out_valid_d = 1'b1;
              out_rob_d   = ent_rob_q[head_q];
              out_value_d = '0;
              set_rep     = 1'b1;
            end
          end else if (commit_cnt_q != '0) begin
            mem_req_d   = 1'b1;
            mem_rw_d    = 1'b1;
            mem_addr_d  = head_addr;
            mem_width_d = head_width;
            mem_wdata_d = ent_v2_q[head_q];
            state_d     = StWait;
          end
        end
      end
      StWait: begin
        if (mem_done) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
          kill_d    = 1'b0;
          if (!kill_q) begin
            pop       = 1'b1;
            store_pop = mem_rw_q;
            if (!mem_rw_q && !flush) begin
              out_valid_d = 1'b1;
              out_rob_d   = ent_rob_q[head_q];
              out_value_d = load_ext;
            end
          end
        end else if (flush && !mem_rw_q) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop)          head_d       = head_q + PtrW'(1);
    if (store_pop)    commit_cnt_d = commit_cnt_q - CntW'(1);
    if (commit_store) commit_cnt_d = commit_cnt_d + CntW'(1);

    if (flush) begin
      count_d = commit_cnt_d;
      tail_d  = head_d + commit_cnt_d[PtrW-1:0];
    end else begin
      if (push) tail_d = tail_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= StIdle;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_cnt_q <= '0;
      kill_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_width_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      out_valid_q  <= 1'b0;
      out_rob_q    <= '0;
      out_value_q  <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      commit_cnt_q <= commit_cnt_d;
      kill_q       <= kill_d;
      mem_req_q    <= mem_req_d;
      mem_rw_q     <= mem_rw_d;
      mem_width_q  <= mem_width_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      out_valid_q  <= out_valid_d;
      out_rob_q    <= out_rob_d;
      out_value_q  <= out_value_d;
    end
  end

  // Entry payload needs no reset: occupancy is defined by head/count alone
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_valid && !ent_r1_q[i] && ent_q1_q[i] == cdb_rob) begin
          ent_r1_q[i] <= 1'b1;
          ent_v1_q[i] <= cdb_value;
        end
        if (cdb_valid && !ent_r2_q[i] && ent_q2_q[i] == cdb_rob) begin
          ent_r2_q[i] <= 1'b1;
          ent_v2_q[i] <= cdb_value;
        end
      end
      if (set_rep) ent_rep_q[head_q] <= 1'b1;
      if (push) begin
        ent_op_q[tail_q]  <= issue_op;
        ent_rob_q[tail_q] <= issue_rob;
        ent_q1_q[tail_q]  <= issue_q1;
        ent_q2_q[tail_q]  <= issue_q2;
        ent_imm_q[tail_q] <= issue_imm;
        ent_rep_q[tail_q] <= 1'b0;
        ent_r1_q[tail_q]  <= issue_q1_rdy || iss_hit1;
        ent_v1_q[tail_q]  <= issue_q1_rdy ? issue_v1 : cdb_value;
        ent_r2_q[tail_q]  <= issue_q2_rdy || iss_hit2;
        ent_v2_q[tail_q]  <= issue_q2_rdy ? issue_v2 : cdb_value;
      end
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
module tb_load_store_queue;
  localparam int RW = 4;
  localparam int DEPTH = 16;

  logic          clk, rst_n, rdy;
  logic          issue_valid, issue_q1_rdy, issue_q2_rdy;
  logic [2:0]    issue_op;
  logic [RW-1:0] issue_rob, issue_q1, issue_q2;
  logic [31:0]   issue_v1, issue_v2, issue_imm;
  logic          lsq_full;
  logic          cdb_valid;
  logic [RW-1:0] cdb_rob, rob_head;
  logic [31:0]   cdb_value;
  logic          commit_store, flush;
  logic          mem_req, mem_rw, mem_done;
  logic [1:0]    mem_width;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic          out_valid;
  logic [RW-1:0] out_rob;
  logic [31:0]   out_value;

  int n_run  = 0;
  int n_fail = 0;

  load_store_queue #(.DEPTH(DEPTH), .ROB_W(RW), .IO_BASE(32'h30000)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rob(issue_rob),
    .issue_q1_rdy(issue_q1_rdy), .issue_v1(issue_v1), .issue_q1(issue_q1),
    .issue_q2_rdy(issue_q2_rdy), .issue_v2(issue_v2), .issue_q2(issue_q2),
    .issue_imm(issue_imm), .lsq_full(lsq_full),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
    .commit_store(commit_store), .rob_head(rob_head), .flush(flush),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_width(mem_width), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_rob(out_rob), .out_value(out_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] v1;
    logic [31:0] imm;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [1:0]  width;
    logic [31:0] value;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [RW-1:0] rob,
                       input logic r1, input logic [31:0] v1, input logic [RW-1:0] q1,
                       input logic r2, input logic [31:0] v2, input logic [RW-1:0] q2,
                       input logic [31:0] imm);
    issue_op = op; issue_rob = rob;
    issue_q1_rdy = r1; issue_v1 = v1; issue_q1 = q1;
    issue_q2_rdy = r2; issue_v2 = v2; issue_q2 = q2;
    issue_imm = imm; issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
  endtask

  // Waits for a request, completes it with rdata, samples out_* one cycle later.
  task automatic serve(input logic [31:0] rdata, output int lat, output logic got_req,
                       output logic [31:0] addr, output logic [1:0] width, output logic rw,
                       output logic [31:0] wdata, output logic got_out,
                       output logic [RW-1:0] orob, output logic [31:0] oval);
    lat = 0;
    while (!mem_req && lat < 50) begin
      tick();
      lat++;
    end
    got_req = mem_req; addr = mem_addr; width = mem_width; rw = mem_rw; wdata = mem_wdata;
    got_out = 1'b0; orob = '0; oval = '0;
    if (got_req) begin
      mem_done = 1'b1; mem_rdata = rdata;
      tick();
      mem_done = 1'b0;
      got_out = out_valid; orob = out_rob; oval = out_value;
    end
  endtask

  initial begin
    int          lat, n, seen;
    logic        got_req, rw, got_out;
    logic [31:0] addr, wdata, oval, exp_addr;
    logic [1:0]  width;
    logic [RW-1:0] orob;

    vecs[0] = '{3'd2, 32'h100,        32'h4,        32'hDEADBEEF, 32'h104, 2'd2, 32'hDEADBEEF};
    vecs[1] = '{3'd0, 32'h200,        32'h0,        32'h00000080, 32'h200, 2'd0, 32'hFFFFFF80};
    vecs[2] = '{3'd4, 32'h200,        32'h1,        32'h00000080, 32'h201, 2'd0, 32'h00000080};
    vecs[3] = '{3'd1, 32'h300,        32'hFFFFFFFE, 32'h00008001, 32'h2FE, 2'd1, 32'hFFFF8001};
    vecs[4] = '{3'd5, 32'h10,         32'h10,       32'h12348001, 32'h020, 2'd1, 32'h00008001};
    vecs[5] = '{3'd0, 32'hFFFFFFFF,   32'h1,        32'h1234567F, 32'h000, 2'd0, 32'h0000007F};

    rdy = 1'b1; rst_n = 1'b0;
    issue_valid = 0; issue_op = 0; issue_rob = 0; issue_q1_rdy = 0; issue_q2_rdy = 0;
    issue_v1 = 0; issue_v2 = 0; issue_q1 = 0; issue_q2 = 0; issue_imm = 0;
    cdb_valid = 0; cdb_rob = 0; cdb_value = 0; commit_store = 0; rob_head = 0;
    flush = 0; mem_done = 0; mem_rdata = 0;

    // Reset
    tick(); tick();
    check("rst lsq_full", lsq_full, 0);
    check("rst mem_req", mem_req, 0);
    check("rst mem_rw", mem_rw, 0);
    check("rst mem_width", mem_width, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_rob", out_rob, 0);
    check("rst out_value", out_value, 0);
    rst_n = 1'b1;
    tick();

    // Loads: address, width, extension, latency
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].op, RW'(i + 1), 1'b1, vecs[i].v1, '0, 1'b1, 32'h0, '0, vecs[i].imm);
      serve(vecs[i].rdata, lat, got_req, addr, width, rw, wdata, got_out, orob, oval);
      check($sformatf("vec%0d latency", i), lat, 1);
      check($sformatf("vec%0d rw", i), rw, 0);
      check($sformatf("vec%0d addr", i), addr, vecs[i].addr);
      check($sformatf("vec%0d width", i), width, vecs[i].width);
      check($sformatf("vec%0d out_valid", i), got_out, 1);
      check($sformatf("vec%0d out_rob", i), orob, i + 1);
      check($sformatf("vec%0d out_value", i), oval, vecs[i].value);
      check($sformatf("vec%0d req dropped", i), mem_req, 0);
    end

    // Store with pending data; report, hold until commit, then write
    issue(3'd7, 4'd5, 1'b1, 32'h400, '0, 1'b0, 32'h0, 4'd3, 32'h8);
    seen = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (out_valid) seen++; end
    check("sw no early report", seen, 0);
    cdb_valid = 1'b1; cdb_rob = 4'd3; cdb_value = 32'h55;
    tick();
    cdb_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    check("sw report valid", out_valid, 1);
    check("sw report rob", out_rob, 5);
    check("sw report value", out_value, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (mem_req || out_valid) seen++; end
    check("sw no req before commit", seen, 0);
    commit_store = 1'b1;
    tick();
    commit_store = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin tick(); n++; end
    check("sw req", mem_req, 1);
    check("sw rw", mem_rw, 1);
    check("sw addr", mem_addr, 32'h408);
    check("sw width", mem_width, 2);
    check("sw wdata", mem_wdata, 32'h55);
    rdy = 1'b0; mem_done = 1'b1;
    tick();
    mem_done = 1'b0; rdy = 1'b1;
    check("sw frozen req", mem_req, 1);
    tick();
    check("sw req held", mem_req, 1);
    check("sw addr held", mem_addr, 32'h408);
    serve(32'h0, lat, got_req, addr, width, rw, wdata, got_out, orob, oval);
    check("sw no load result", got_out, 0);
    check("sw req dropped", mem_req, 0);

    // Fill, overflow drop, issue after pop
    for (int i = 0; i < DEPTH; i++) begin
      issue(3'd2, RW'(i), 1'b0, 32'h0, 4'd9, 1'b1, 32'h0, '0, 32'(i * 4));
      if (i == DEPTH - 2) check("fill not full at 15", lsq_full, 0);
    end
    check("fill full", lsq_full, 1);
    issue(3'd2, 4'hF, 1'b1, 32'h9000, '0, 1'b1, 32'h0, '0, 32'h999);
    check("full after drop", lsq_full, 1);
    cdb_valid = 1'b1; cdb_rob = 4'd9; cdb_value = 32'h1000;
    tick();
    cdb_valid = 1'b0;
    serve(32'h1000, lat, got_req, addr, width, rw, wdata, got_out, orob, oval);
    check("full pop0 value", oval, 32'h1000);
    check("not full after pop", lsq_full, 0);
    issue(3'd2, 4'hE, 1'b1, 32'h1000, '0, 1'b1, 32'h0, '0, 32'h777);
    for (int i = 1; i <= DEPTH; i++) begin
      exp_addr = (i == DEPTH) ? 32'h1777 : 32'h1000 + 32'(i * 4);
      serve(exp_addr, lat, got_req, addr, width, rw, wdata, got_out, orob, oval);
      check($sformatf("drain%0d addr", i), addr, exp_addr);
      check($sformatf("drain%0d value", i), oval, exp_addr);
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (mem_req) seen++; end
    check("drained idle", seen, 0);

    // Flush: committed store at head survives, three loads behind it vanish
    issue(3'd7, 4'd1, 1'b1, 32'h500, '0, 1'b1, 32'hAA, '0, 32'h0);
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    check("fl sw report", out_valid, 1);
    check("fl sw rob", out_rob, 1);
    issue(3'd0, 4'd2, 1'b0, 32'h0, 4'd9, 1'b1, 32'h0, '0, 32'h0);
    issue(3'd1, 4'd3, 1'b0, 32'h0, 4'd9, 1'b1, 32'h0, '0, 32'h0);
    issue(3'd2, 4'd4, 1'b0, 32'h0, 4'd9, 1'b1, 32'h0, '0, 32'h0);
    commit_store = 1'b1;
    tick();
    commit_store = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; cdb_valid = 1'b1; cdb_rob = 4'd9; cdb_value = 32'h40;
    tick();
    cdb_valid = 1'b0;
    serve(32'h0, lat, got_req, addr, width, rw, wdata, got_out, orob, oval);
    check("fl sw req", got_req, 1);
    check("fl sw rw", rw, 1);
    check("fl sw addr", addr, 32'h500);
    check("fl sw wdata", wdata, 32'hAA);
    check("fl sw no out", got_out, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (mem_req || out_valid) seen++; end
    check("fl loads gone", seen, 0);
    for (int i = 0; i < DEPTH; i++) begin
      issue(3'd2, RW'(i), 1'b0, 32'h0, 4'd10, 1'b1, 32'h0, '0, 32'h0);
      if (i == DEPTH - 2) check("fl count zero (15 not full)", lsq_full, 0);
    end
    check("fl refill full", lsq_full, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl clears all", lsq_full, 0);

    // Flush during an in-flight load: handshake completes, result dropped
    issue(3'd2, 4'd8, 1'b1, 32'h600, '0, 1'b1, 32'h0, '0, 32'h0);
    n = 0;
    while (!mem_req && n < 10) begin tick(); n++; end
    check("kill req", mem_req, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("kill req held", mem_req, 1);
    serve(32'h1234, lat, got_req, addr, width, rw, wdata, got_out, orob, oval);
    check("kill no out", got_out, 0);
    check("kill req dropped", mem_req, 0);
    issue(3'd2, 4'd7, 1'b1, 32'h700, '0, 1'b1, 32'h0, '0, 32'h0);
    serve(32'hCAFEF00D, lat, got_req, addr, width, rw, wdata, got_out, orob, oval);
    check("post-kill addr", addr, 32'h700);
    check("post-kill value", oval, 32'hCAFEF00D);
    check("post-kill rob", orob, 7);

    // IO load
    rob_head = 4'd2;
    issue(3'd2, 4'd6, 1'b1, 32'h30000, '0, 1'b1, 32'h0, '0, 32'h0);
`ifdef LSQ_IO_SAFE_EN
    seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (mem_req) seen++; end
    check("io held off", seen, 0);
    rob_head = 4'd6;
    serve(32'h11, lat, got_req, addr, width, rw, wdata, got_out, orob, oval);
    check("io issued at head", got_req, 1);
`else
    serve(32'h11, lat, got_req, addr, width, rw, wdata, got_out, orob, oval);
    check("io latency", lat, 1);
`endif
    check("io addr", addr, 32'h30000);
    check("io value", oval, 32'h11);
    rob_head = 4'd0;

    // Back-to-back stream across three pointer wraps
    for (int i = 0; i < 3 * DEPTH; i++) begin
      issue(3'd2, RW'(i), 1'b1, 32'h2000, '0, 1'b1, 32'h0, '0, 32'(i * 8));
      serve(32'(i) * 32'h01010101, lat, got_req, addr, width, rw, wdata, got_out, orob, oval);
      check($sformatf("wrap%0d addr", i), addr, 32'h2000 + 32'(i * 8));
      check($sformatf("wrap%0d value", i), oval, 32'(i) * 32'h01010101);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
